// File: rtl/linear_regression_ctrl.sv
// Sequential price estimator: out_price = intercept + slope * size.
// The product is built by a 16-step LSB-first shift-add multiplier, then the intercept is added in one final step.
module linear_regression_ctrl #(
    parameter logic [15:0] DEF_INTERCEPT = 16'd10000,
    parameter logic [15:0] DEF_SLOPE     = 16'd5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic        cfg_sel,
    input  logic [15:0] cfg_data,
    input  logic        in_valid,
    input  logic [15:0] in_size,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_price,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] intercept_r, slope_r;
    logic [15:0] size_w, slope_w, icpt_w;
    logic [31:0] acc;
    logic [3:0]  cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = MUL;
            end
            MUL:  if (cnt == 4'd15) state_nxt = ADD;
            ADD:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
        endcase
    end

    // Coefficients are snapshotted at accept, so a concurrent or later cfg write only affects later jobs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            intercept_r <= DEF_INTERCEPT;
            slope_r     <= DEF_SLOPE;
            cnt         <= '0;
            acc         <= '0;
            out_price   <= '0;
        end else begin
            if (cfg_we) begin
                if (cfg_sel) slope_r     <= cfg_data;
                else         intercept_r <= cfg_data;
            end
            case (state)
                IDLE: if (in_valid) begin
                    size_w  <= in_size;
                    slope_w <= slope_r;
                    icpt_w  <= intercept_r;
                    acc     <= '0;
                    cnt     <= '0;
                end
                MUL: begin
                    if (size_w[cnt]) acc <= acc + ({16'd0, slope_w} << cnt);
                    cnt <= cnt + 4'd1;
                end
                ADD:     out_price <= acc + {16'd0, icpt_w};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_linear_regression_ctrl.sv
// Self-checking bench for linear_regression_ctrl: directed scenarios plus randomized jobs
// compared against an arithmetic price model (intercept + slope*size).
module tb_linear_regression_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, cfg_we, cfg_sel, in_valid, out_ready;
    logic [15:0] cfg_data, in_size;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_price;

    int errors = 0;
    int checks = 0;
    logic [15:0] m_icpt, m_slope;

    linear_regression_ctrl #(.DEF_INTERCEPT(16'd10000), .DEF_SLOPE(16'd5000)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_size(in_size), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_price(out_price), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_price(input logic [15:0] i, input logic [15:0] s, input logic [15:0] z);
        return {16'd0, i} + 32'(s) * 32'(z);
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_size = '0;
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_data = 16'd123;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; cfg_we = 1'b0;
        m_icpt = 16'd10000; m_slope = 16'd5000;
    endtask

    task automatic cfg_write(input logic sel, input logic [15:0] d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_data = d;
        @(posedge clk); @(negedge clk);
        cfg_we = 1'b0;
        if (sel) m_slope = d; else m_icpt = d;
    endtask

    // Waits (bounded) for out_valid; lat counts edges since the accept edge, -1 on timeout.
    task automatic wait_done(input int start, output logic [31:0] price, output int lat, output bit busy_ok);
        lat = -1; busy_ok = busy;
        for (int c = start + 1; c <= 60; c++) begin
            @(posedge clk); @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (out_valid) begin lat = c; break; end
        end
        price = out_price;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_job(input logic [15:0] size, input bit hs, output logic [31:0] price,
                          output int lat, output bit busy_ok);
        in_valid = 1'b1; in_size = size; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        wait_done(0, price, lat, busy_ok);
        if (hs && lat > 0) handshake();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_price !== 32'd0) begin errors++; $display("FAIL reset_out_price got=%0d exp=0", out_price); end
    endtask

    task automatic test_basic();
        logic [31:0] p; int lat; bit bok;
        do_job(16'd3, 1'b1, p, lat, bok);
        checks++; if (lat !== 17) begin errors++; $display("FAIL basic_latency got=%0d exp=17", lat); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", bok); end
        checks++; if (p !== 32'd25000) begin errors++; $display("FAIL basic_price got=%0d exp=25000", p); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_return_idle got=%b%b exp=10", in_ready, out_valid); end
        checks++; if (out_price !== 32'd25000) begin errors++; $display("FAIL basic_price_retained got=%0d exp=25000", out_price); end
    endtask

    task automatic test_extremes();
        logic [31:0] p; int lat; bit bok;
        cfg_write(1'b0, 16'hFFFF);
        cfg_write(1'b1, 16'hFFFF);
        do_job(16'hFFFF, 1'b1, p, lat, bok);
        checks++; if (p !== 32'd4294901760) begin errors++; $display("FAIL extreme_max got=%0d exp=4294901760", p); end
        do_job(16'd0, 1'b1, p, lat, bok);
        checks++; if (p !== 32'd65535) begin errors++; $display("FAIL extreme_size0 got=%0d exp=65535", p); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL extreme_size0_latency got=%0d exp=17", lat); end
        cfg_write(1'b1, 16'd0);
        do_job(16'd1234, 1'b1, p, lat, bok);
        checks++; if (p !== 32'd65535 || lat !== 17) begin
            errors++; $display("FAIL extreme_slope0 got=%0d/%0d exp=65535/17", p, lat); end
    endtask

    task automatic test_backpressure();
        logic [31:0] p, exp; int lat; bit bok;
        exp = ref_price(m_icpt, m_slope, 16'd5);
        do_job(16'd5, 1'b0, p, lat, bok);
        checks++; if (p !== exp) begin errors++; $display("FAIL bp_price got=%0d exp=%0d", p, exp); end
        in_valid = 1'b1; in_size = 16'd9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_price !== p) begin
                errors++; $display("FAIL bp_hold cycle=%0d got=%b%b/%0d exp=10/%0d", i, out_valid, in_ready, out_price, p); end
        end
        handshake();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got=%b%b%b exp=100", in_ready, busy, out_valid); end
        in_valid = 1'b0;
    endtask

    task automatic test_cfg_during_mul();
        logic [31:0] p; int lat; bit bok;
        do_reset();
        in_valid = 1'b1; in_size = 16'd2;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        cfg_write(1'b1, 16'd1);
        wait_done(5, p, lat, bok);
        checks++; if (p !== 32'd20000 || lat !== 17) begin
            errors++; $display("FAIL cfg_mul_old got=%0d/%0d exp=20000/17", p, lat); end
        handshake();
        do_job(16'd2, 1'b1, p, lat, bok);
        checks++; if (p !== 32'd10002) begin errors++; $display("FAIL cfg_mul_new got=%0d exp=10002", p); end
    endtask

    task automatic test_cfg_same_cycle();
        logic [31:0] p, exp_old; int lat; bit bok;
        exp_old = ref_price(m_icpt, m_slope, 16'd4);
        in_valid = 1'b1; in_size = 16'd4;
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 16'd777;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0; m_icpt = 16'd777;
        wait_done(0, p, lat, bok);
        checks++; if (p !== exp_old) begin errors++; $display("FAIL same_cycle_old got=%0d exp=%0d", p, exp_old); end
        handshake();
        do_job(16'd4, 1'b1, p, lat, bok);
        checks++; if (p !== ref_price(m_icpt, m_slope, 16'd4)) begin
            errors++; $display("FAIL same_cycle_new got=%0d exp=%0d", p, ref_price(m_icpt, m_slope, 16'd4)); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] p; int lat; bit bok, seen;
        cfg_write(1'b1, 16'd321);
        in_valid = 1'b1; in_size = 16'd3;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (7) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1; m_icpt = 16'd10000; m_slope = 16'd5000;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset_idle got=%b%b exp=01", busy, in_ready); end
        seen = 1'b0;
        repeat (25) begin @(posedge clk); @(negedge clk); if (out_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_no_output got=%b exp=0", seen); end
        do_job(16'd1, 1'b1, p, lat, bok);
        checks++; if (p !== 32'd15000) begin errors++; $display("FAIL mid_reset_defaults got=%0d exp=15000", p); end
    endtask

    task automatic test_random();
        logic [31:0] p, exp; int lat; bit bok;
        logic [15:0] sz;
        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 1) == 1) cfg_write(1'($urandom_range(0, 1)), 16'($urandom));
            sz = 16'($urandom);
            exp = ref_price(m_icpt, m_slope, sz);
            do_job(sz, 1'b1, p, lat, bok);
            checks++; if (p !== exp || lat !== 17) begin
                errors++; $display("FAIL random_job n=%0d size=%0d got=%0d/%0d exp=%0d/17", n, sz, p, lat, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res[$];
        int acc_t[$];
        int sizes[3];
        int nacc;
        bit acc_now;
        do_reset();
        sizes = '{1, 2, 3};
        nacc = 0;
        in_valid = 1'b1; in_size = 16'(sizes[0]); out_ready = 1'b1;
        for (int t = 0; t < 150 && res.size() < 3; t++) begin
            acc_now = in_valid && in_ready;
            @(posedge clk); @(negedge clk);
            if (acc_now) begin
                acc_t.push_back(t); nacc++;
                if (nacc < 3) in_size = 16'(sizes[nacc]); else in_valid = 1'b0;
            end
            if (out_valid) res.push_back(out_price);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= res.size()) begin
                errors++; $display("FAIL b2b_result%0d got=missing exp=%0d", i, ref_price(16'd10000, 16'd5000, 16'(sizes[i])));
            end else if (res[i] !== ref_price(16'd10000, 16'd5000, 16'(sizes[i]))) begin
                errors++; $display("FAIL b2b_result%0d got=%0d exp=%0d", i, res[i], ref_price(16'd10000, 16'd5000, 16'(sizes[i])));
            end
        end
        checks++;
        if (acc_t.size() != 3) begin
            errors++; $display("FAIL b2b_accepts got=%0d exp=3", acc_t.size());
        end else if (acc_t[1] - acc_t[0] != 19 || acc_t[2] - acc_t[1] != 19) begin
            errors++; $display("FAIL b2b_spacing got=%0d,%0d exp=19,19", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_data = '0;
        in_valid = 1'b0; in_size = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_cfg_during_mul();
        test_cfg_same_cycle();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
